branching_control_path: RTL and testbench



---
 rtl/branching_control_path_pkg.sv | 34 +++
 rtl/switch_sync_edge.sv | 26 ++
 rtl/branching_control_path.sv | 108 ++++++++++
 tb/tb_branching_control_path.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branching_control_path_pkg.sv
// Shared picoMIPS control-path types: opcodes, ALU function codes and control FSM states.
package cpu_config;

    typedef enum logic [5:0] {
        OP_NOP    = 6'h00,
        OP_ADD    = 6'h01,
        OP_ADDI   = 6'h02,
        OP_SUB    = 6'h03,
        OP_SUBI   = 6'h04,
        OP_MUL    = 6'h05,
        OP_MULI   = 6'h06,
        OP_J      = 6'h10,
        OP_BEQ    = 6'h11,
        OP_BNE    = 6'h12,
        OP_WAITSW = 6'h20,
        OP_LDSW   = 6'h21,
        OP_HALT   = 6'h3F
    } opCode_t;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_MUL  = 3'd3
    } aluFunc_t;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } cpState_t;

endpackage

// File: rtl/switch_sync_edge.sv
// Synchronises the asynchronous go switch and flags its rising edge.
// Latency: rise appears two edges after the input goes high; single-cycle pulse, no backpressure.
module switch_sync_edge (
    input  logic clk,
    input  logic nRst,
    input  logic async_in,
    output logic rise
);

    logic sync1, sync2, prev;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/branching_control_path.sv
// picoMIPS control path: program counter, branch/jump/run-control FSM and instruction decode.
// Latency: decode is combinational; PC updates one edge after the instruction is presented.
// Backpressure: none; WAIT stalls until a fresh switch rise, HALT holds until reset.
module branching_control_path
    import cpu_config::*;
#(
    parameter  int N      = 8,
    parameter  int A_SIZE = 3,
    parameter  int O_SIZE = 6,
    parameter  int P_SIZE = 5,
    parameter  int R_SIZE = 3,
    localparam int I_SIZE = O_SIZE + 2 * R_SIZE + N
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [I_SIZE-1:0] instruction,
    input  logic              zeroFlag,
    input  logic              goSwitch,
    output logic [P_SIZE-1:0] pcAddr,
    output logic              writeReg,
    output logic [A_SIZE-1:0] aluFunc,
    output logic              aluImmediate,
    output logic              immSwitches,
    output logic [R_SIZE-1:0] opD,
    output logic [R_SIZE-1:0] opS,
    output logic [N-1:0]      opT,
    output logic              halted,
    output logic              waiting
);

    cpState_t          state_q, state_d;
    logic [P_SIZE-1:0] pc_d, pc_inc, target;
    opCode_t           op;
    aluFunc_t          alu_func;
    logic              rise;

    assign op  = opCode_t'(instruction[I_SIZE-1 -: O_SIZE]);
    assign opD = instruction[2*R_SIZE+N-1 -: R_SIZE];
    assign opS = instruction[R_SIZE+N-1 -: R_SIZE];
    assign opT = instruction[N-1:0];

    // Only the low P_SIZE bits of the target field address program memory.
    assign target  = opT[P_SIZE-1:0];
    assign pc_inc  = pcAddr + P_SIZE'(1);
    assign aluFunc = alu_func;

    switch_sync_edge u_go (
        .clk      (clk),
        .nRst     (nRst),
        .async_in (goSwitch),
        .rise     (rise)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= ST_BOOT;
            pcAddr  <= '0;
        end else begin
            state_q <= state_d;
            pcAddr  <= pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pcAddr;
        writeReg     = 1'b0;
        alu_func     = ALU_PASS;
        aluImmediate = 1'b0;
        immSwitches  = 1'b0;
        halted       = (state_q == ST_HALT);
        waiting      = (state_q == ST_WAIT);
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                pc_d = pc_inc;
                case (op)
                    OP_ADD:  begin writeReg = 1'b1; alu_func = ALU_ADD; end
                    OP_ADDI: begin writeReg = 1'b1; alu_func = ALU_ADD; aluImmediate = 1'b1; end
                    OP_SUB:  begin writeReg = 1'b1; alu_func = ALU_SUB; end
                    OP_SUBI: begin writeReg = 1'b1; alu_func = ALU_SUB; aluImmediate = 1'b1; end
                    OP_MUL:  begin writeReg = 1'b1; alu_func = ALU_MUL; end
                    OP_MULI: begin writeReg = 1'b1; alu_func = ALU_MUL; aluImmediate = 1'b1; end
                    OP_LDSW: begin
                        writeReg     = 1'b1;
                        alu_func     = ALU_PASS;
                        aluImmediate = 1'b1;
                        immSwitches  = 1'b1;
                    end
                    OP_J:   pc_d = target;
                    OP_BEQ: if (zeroFlag)  pc_d = target;
                    OP_BNE: if (!zeroFlag) pc_d = target;
                    OP_WAITSW: begin pc_d = pcAddr; state_d = ST_WAIT; end
                    OP_HALT:   begin pc_d = pcAddr; state_d = ST_HALT; end
                    default: ;
                endcase
            end
            // Switch edges seen outside WAIT are simply never looked at.
            ST_WAIT: if (rise) begin
                pc_d    = pc_inc;
                state_d = ST_RUN;
            end
            ST_HALT: ;
            default: state_d = ST_BOOT;
        endcase
    end

endmodule

// File: tb/tb_branching_control_path.sv
module tb_branching_control_path;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic [19:0] instruction = '0;
    logic        zeroFlag = 1'b0;
    logic        goSwitch = 1'b0;
    logic [4:0]  pcAddr;
    logic        writeReg;
    logic [2:0]  aluFunc;
    logic        aluImmediate;
    logic        immSwitches;
    logic [2:0]  opD, opS;
    logic [7:0]  opT;
    logic        halted, waiting;

    int total = 0;
    int bad = 0;

    branching_control_path #(.N(8), .A_SIZE(3), .O_SIZE(6), .P_SIZE(5), .R_SIZE(3)) dut (
        .clk(clk), .nRst(nRst), .instruction(instruction), .zeroFlag(zeroFlag),
        .goSwitch(goSwitch), .pcAddr(pcAddr), .writeReg(writeReg), .aluFunc(aluFunc),
        .aluImmediate(aluImmediate), .immSwitches(immSwitches), .opD(opD), .opS(opS),
        .opT(opT), .halted(halted), .waiting(waiting)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    localparam logic [5:0] NOP = 6'h00, ADD = 6'h01, ADDI = 6'h02, SUB = 6'h03, SUBI = 6'h04,
                           MUL = 6'h05, MULI = 6'h06, J = 6'h10, BEQ = 6'h11, BNE = 6'h12,
                           WAITSW = 6'h20, LDSW = 6'h21, HALT = 6'h3F;

    typedef struct {
        logic [5:0] op;
        logic [7:0] t;
        logic       z;
        logic [4:0] start;
        logic       wr;
        logic [2:0] fn;
        logic       imm;
        logic       sw;
        logic [4:0] npc;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [19:0] mk(input logic [5:0] op, input logic [2:0] d,
                                       input logic [2:0] s, input logic [7:0] t);
        return {op, d, s, t};
    endfunction

    // Reference next-PC from the architectural rules, in plain integer arithmetic mod 32.
    function automatic logic [4:0] ref_pc(input logic [5:0] op, input int pc,
                                          input int t, input logic z);
        int nxt;
        nxt = (pc + 1) % 32;
        if (op == J) nxt = t % 32;
        else if (op == BEQ && z) nxt = t % 32;
        else if (op == BNE && !z) nxt = t % 32;
        return nxt[4:0];
    endfunction

    // Reference control word {writeReg, aluFunc, aluImmediate, immSwitches} for a RUN-state opcode.
    function automatic logic [5:0] ref_ctl(input logic [5:0] op);
        case (op)
            ADD:  return {1'b1, 3'd1, 1'b0, 1'b0};
            ADDI: return {1'b1, 3'd1, 1'b1, 1'b0};
            SUB:  return {1'b1, 3'd2, 1'b0, 1'b0};
            SUBI: return {1'b1, 3'd2, 1'b1, 1'b0};
            MUL:  return {1'b1, 3'd3, 1'b0, 1'b0};
            MULI: return {1'b1, 3'd3, 1'b1, 1'b0};
            LDSW: return {1'b1, 3'd0, 1'b1, 1'b1};
            default: return 6'b0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{ADDI,   8'h5A, 1'b0, 5'd0,  1'b1, 3'd1, 1'b1, 1'b0, 5'd1};
        vecs[1]  = '{J,      8'h97, 1'b0, 5'd3,  1'b0, 3'd0, 1'b0, 1'b0, 5'd23};
        vecs[2]  = '{BEQ,    8'h09, 1'b1, 5'd4,  1'b0, 3'd0, 1'b0, 1'b0, 5'd9};
        vecs[3]  = '{BEQ,    8'h09, 1'b0, 5'd4,  1'b0, 3'd0, 1'b0, 1'b0, 5'd5};
        vecs[4]  = '{BNE,    8'h09, 1'b0, 5'd4,  1'b0, 3'd0, 1'b0, 1'b0, 5'd9};
        vecs[5]  = '{BNE,    8'h09, 1'b1, 5'd4,  1'b0, 3'd0, 1'b0, 1'b0, 5'd5};
        vecs[6]  = '{NOP,    8'h00, 1'b0, 5'd31, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0};
        vecs[7]  = '{LDSW,   8'h03, 1'b0, 5'd10, 1'b1, 3'd0, 1'b1, 1'b1, 5'd11};
        vecs[8]  = '{SUB,    8'h44, 1'b1, 5'd12, 1'b1, 3'd2, 1'b0, 1'b0, 5'd13};
        vecs[9]  = '{MULI,   8'hC1, 1'b0, 5'd13, 1'b1, 3'd3, 1'b1, 1'b0, 5'd14};
        vecs[10] = '{6'h15,  8'h07, 1'b1, 5'd14, 1'b0, 3'd0, 1'b0, 1'b0, 5'd15};
        vecs[11] = '{BEQ,    8'hE2, 1'b1, 5'd30, 1'b0, 3'd0, 1'b0, 1'b0, 5'd2};
        vecs[12] = '{ADD,    8'h10, 1'b0, 5'd2,  1'b1, 3'd1, 1'b0, 1'b0, 5'd3};
        vecs[13] = '{MUL,    8'hFF, 1'b1, 5'd20, 1'b1, 3'd3, 1'b0, 1'b0, 5'd21};
        vecs[14] = '{SUBI,   8'h01, 1'b0, 5'd21, 1'b1, 3'd2, 1'b1, 1'b0, 5'd22};

        // Reset state
        #12;
        chk("rst_pc", pcAddr, 0);
        chk("rst_wr", writeReg, 0);
        chk("rst_halted", halted, 0);
        chk("rst_waiting", waiting, 0);
        chk("rst_func", {aluFunc, aluImmediate, immSwitches}, 0);

        // BOOT cycle: ADDI is presented but must not execute
        instruction = mk(ADDI, 3'd2, 3'd1, 8'h5A);
        @(negedge clk);
        nRst = 1'b1;
        #1;
        chk("boot_wr", writeReg, 0);
        tick();
        chk("boot_pc_hold", pcAddr, 0);
        chk("addi_wr", writeReg, 1);
        chk("addi_imm", aluImmediate, 1);
        chk("addi_func", aluFunc, 1);
        chk("addi_opT", opT, 8'h5A);
        tick();
        chk("addi_pc", pcAddr, 1);

        // NOP program steps through and wraps 31 -> 0
        instruction = mk(NOP, 3'd0, 3'd0, 8'h00);
        for (int i = 2; i <= 33; i++) begin
            tick();
            chk($sformatf("nop_step%0d", i), pcAddr, i % 32);
        end

        // Table-driven single-instruction vectors
        for (int v = 0; v < 15; v++) begin
            instruction = mk(J, 3'd0, 3'd0, {3'b000, vecs[v].start});
            tick();
            chk($sformatf("vec%0d_start", v), pcAddr, vecs[v].start);
            instruction = mk(vecs[v].op, 3'(v), 3'(7 - (v % 8)), vecs[v].t);
            zeroFlag = vecs[v].z;
            #1;
            chk($sformatf("vec%0d_ctl", v), {writeReg, aluFunc, aluImmediate, immSwitches},
                {vecs[v].wr, vecs[v].fn, vecs[v].imm, vecs[v].sw});
            chk($sformatf("vec%0d_fields", v), {opD, opS, opT},
                {3'(v), 3'(7 - (v % 8)), vecs[v].t});
            tick();
            chk($sformatf("vec%0d_npc", v), pcAddr, vecs[v].npc);
        end

        // Randomised RUN-state instructions against the reference model
        begin
            int mpc;
            logic [5:0] op;
            logic [7:0] t;
            logic z;
            instruction = mk(J, 3'd0, 3'd0, 8'h00);
            tick();
            mpc = 0;
            chk("rnd_start", pcAddr, 0);
            for (int k = 0; k < 200; k++) begin
                case ($urandom_range(0, 3))
                    0: op = 6'($urandom_range(0, 63));
                    1: op = 6'($urandom_range(0, 6));
                    2: op = ($urandom_range(0, 1) != 0) ? BEQ : BNE;
                    default: op = ($urandom_range(0, 1) != 0) ? J : LDSW;
                endcase
                if (op == WAITSW || op == HALT) op = NOP;
                t = 8'($urandom);
                z = 1'($urandom);
                instruction = mk(op, 3'($urandom), 3'($urandom), t);
                zeroFlag = z;
                #1;
                chk($sformatf("rnd%0d_ctl op=%0h", k, op),
                    {writeReg, aluFunc, aluImmediate, immSwitches}, ref_ctl(op));
                tick();
                mpc = int'(ref_pc(op, mpc, int'(t), z));
                chk($sformatf("rnd%0d_pc op=%0h", k, op), pcAddr, mpc);
            end
        end

        // WAITSW entered with the switch already high: no release without a fresh rise
        zeroFlag = 1'b0;
        goSwitch = 1'b1;
        instruction = mk(NOP, 3'd0, 3'd0, 8'h00);
        repeat (3) tick();
        instruction = mk(J, 3'd0, 3'd0, 8'd6);
        tick();
        chk("wait_start", pcAddr, 6);
        instruction = mk(WAITSW, 3'd0, 3'd0, 8'h00);
        #1;
        chk("waitsw_run_waiting", waiting, 0);
        chk("waitsw_run_wr", writeReg, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wait_hi%0d", i), {pcAddr, waiting, writeReg}, {5'd6, 1'b1, 1'b0});
            tick();
        end
        goSwitch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("wait_lo%0d", i), {pcAddr, waiting, writeReg}, {5'd6, 1'b1, 1'b0});
        end
        goSwitch = 1'b1;
        tick();
        chk("wait_e1", {pcAddr, waiting, writeReg}, {5'd6, 1'b1, 1'b0});
        tick();
        chk("wait_e2", {pcAddr, waiting, writeReg}, {5'd6, 1'b1, 1'b0});
        tick();
        chk("wait_e3", {pcAddr, waiting}, {5'd7, 1'b0});
        instruction = mk(NOP, 3'd0, 3'd0, 8'h00);
        tick();
        chk("wait_resume", pcAddr, 8);

        // HALT holds through switch activity until reset
        instruction = mk(HALT, 3'd0, 3'd0, 8'h00);
        tick();
        for (int i = 0; i < 20; i++) begin
            goSwitch = ~goSwitch;
            chk($sformatf("halt%0d", i), {pcAddr, halted, waiting, writeReg},
                {5'd8, 1'b1, 1'b0, 1'b0});
            tick();
        end
        nRst = 1'b0;
        #1;
        chk("halt_rst_pc", pcAddr, 0);
        chk("halt_rst_halted", halted, 0);
        instruction = mk(ADDI, 3'd1, 3'd1, 8'h01);
        @(negedge clk);
        nRst = 1'b1;
        #1;
        chk("reboot_wr", writeReg, 0);
        tick();
        chk("reboot_pc", pcAddr, 0);
        chk("reboot_run_wr", writeReg, 1);
        tick();
        chk("reboot_step", pcAddr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
